systolic_result_drain: RTL

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_pkg.sv | 13 +
 rtl/systolic_set_fifo.sv | 54 +++++
 rtl/systolic_result_drain.sv | 124 ++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic result drain
package systolic_pkg;

  localparam int ACC_WIDTH_DEF = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } drain_state_t;

  typedef logic [1:0] elem_idx_t;

endpackage

// File: rtl/systolic_set_fifo.sv
// rtl/systolic_set_fifo.sv - power-of-two deep buffer of packed 2x2 result sets
module systolic_set_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Set storage; the caller only pushes when a slot is free or the head is leaving.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - buffers 2x2 result sets and streams them one element per cycle
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int DEPTH     = 2,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] c00,
  input  logic [ACC_WIDTH-1:0] c01,
  input  logic [ACC_WIDTH-1:0] c10,
  input  logic [ACC_WIDTH-1:0] c11,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic [1:0]           m_idx,
  output logic                 m_last,
  output logic [LVL_W-1:0]     level,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  drain_state_t           state_q;
  drain_state_t           state_d;
  elem_idx_t              idx_q;
  elem_idx_t              idx_d;
  logic [4*ACC_WIDTH-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   xfer;
  logic                   last_xfer;
  logic                   push;
  logic                   drop;
  logic [ACC_WIDTH-1:0]   head_elem;

  // A full buffer can still take a set when the head set finishes in the same cycle.
  assign xfer      = m_valid && m_ready;
  assign last_xfer = xfer && (idx_q == 2'd3);
  assign push      = in_valid && (!full || last_xfer);
  assign drop      = in_valid && !push;

  systolic_set_fifo #(
    .WIDTH (4*ACC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata ({c00, c01, c10, c11}),
    .pop   (last_xfer),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Serializer state and element index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: leave SEND only when the last element of the last stored set goes out.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (!empty) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
        end
        if (last_xfer && (level == LVL_W'(1)) && !push) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Pick the current element of the head set; the set is packed c00 in the top slice.
  always_comb begin
    head_elem = '0;
    case (idx_q)
      2'd0:    head_elem = head[4*ACC_WIDTH-1 -: ACC_WIDTH];
      2'd1:    head_elem = head[3*ACC_WIDTH-1 -: ACC_WIDTH];
      2'd2:    head_elem = head[2*ACC_WIDTH-1 -: ACC_WIDTH];
      default: head_elem = head[ACC_WIDTH-1 -: ACC_WIDTH];
    endcase
  end

  assign m_valid = (state_q == S_SEND);
  assign m_data  = m_valid ? head_elem : '0;
  assign m_idx   = idx_q;
  assign m_last  = m_valid && (idx_q == 2'd3);

  // Sticky drop flag; a fresh drop wins over a concurrent clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
